// File: rtl/pe_v2.sv
// ============================================================================
// pe_v2 -- next-generation processing element for the systolic array
//
// Fixed-point MAC cell that tiles north/west -> south/east like the original
// weight-stationary PE. There are two runtime modes, selected when a buffer
// switch happens:
//   WS (weight-stationary): the psum flows north -> south. The PE adds
//       sat(input * active_weight) to the incoming psum and registers the
//       result.
//   OS (output-stationary): the PE multiplies the streamed weight by the
//       activation and accumulates locally. A drain strobe emits the
//       accumulator. Between drains the PE forwards upstream drained values
//       south.
// All arithmetic is two's complement Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS and
// saturates. Any saturation, or an upstream value lost to a drain collision,
// sets a sticky overflow flag.
//
// Parameters:
//   DATA_WIDTH  width of activations, weights and psums
//   FRAC_BITS   fractional bits of the fixed-point format
//   ACC_GUARD   extra integer bits on the OS accumulator
//
// Ports:
//   clk                 rising-edge clock
//   rst_n               asynchronous active-low reset
//   pe_psum_in          north psum (WS) / upstream drained value (OS)
//   pe_psum_valid_in    qualifies pe_psum_in
//   pe_weight_in        north weight (loaded in WS, streamed in OS)
//   pe_accept_w_in      weight-load strobe
//   pe_input_in         west activation
//   pe_valid_in         qualifies pe_input_in
//   pe_switch_in        swap weight buffers and latch pe_mode_in
//   pe_mode_in          0 = WS, 1 = OS
//   pe_drain_in         OS: emit and clear the accumulator
//   pe_clr_ovf_in       clear the sticky overflow flag
//   pe_psum_out         registered south psum
//   pe_psum_valid_out   qualifies pe_psum_out
//   pe_weight_out       registered south weight (0 when not loading)
//   pe_accept_w_out     registered pe_accept_w_in
//   pe_input_out        registered east activation (holds when not valid)
//   pe_valid_out        registered pe_valid_in
//   pe_switch_out       registered pe_switch_in
//   pe_drain_out        registered pe_drain_in
//   pe_overflow_out     sticky saturation / collision flag
// ============================================================================
module pe_v2 #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int ACC_GUARD  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] pe_psum_in,
    input  logic                  pe_psum_valid_in,
    input  logic [DATA_WIDTH-1:0] pe_weight_in,
    input  logic                  pe_accept_w_in,
    input  logic [DATA_WIDTH-1:0] pe_input_in,
    input  logic                  pe_valid_in,
    input  logic                  pe_switch_in,
    input  logic                  pe_mode_in,
    input  logic                  pe_drain_in,
    input  logic                  pe_clr_ovf_in,
    output logic [DATA_WIDTH-1:0] pe_psum_out,
    output logic                  pe_psum_valid_out,
    output logic [DATA_WIDTH-1:0] pe_weight_out,
    output logic                  pe_accept_w_out,
    output logic [DATA_WIDTH-1:0] pe_input_out,
    output logic                  pe_valid_out,
    output logic                  pe_switch_out,
    output logic                  pe_drain_out,
    output logic                  pe_overflow_out
);

    localparam int W   = DATA_WIDTH;
    localparam int PW  = 2 * DATA_WIDTH;
    localparam int AW  = DATA_WIDTH + ACC_GUARD;
    localparam int W1  = W + 1;
    localparam int AW1 = AW + 1;

    localparam logic [W-1:0]  SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]  SAT_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

    typedef enum logic {
        MODE_WS = 1'b0,
        MODE_OS = 1'b1
    } pe_mode_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    pe_mode_t       r_mode;
    logic [W-1:0]   r_activeW;
    logic [W-1:0]   r_inactiveW;
    logic [AW-1:0]  r_acc;
    logic [W-1:0]   r_psumOut;
    logic           r_psumValid;
    logic [W-1:0]   r_weightOut;
    logic           r_acceptW;
    logic [W-1:0]   r_inputOut;
    logic           r_validOut;
    logic           r_switchOut;
    logic           r_drainOut;
    logic           r_ovf;

    // ------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------
    logic [W-1:0]          w_mulWeight;
    logic signed [PW-1:0]  w_prodFull;
    logic signed [PW-1:0]  w_prodShift;
    logic [PW-W:0]         w_prodHigh;
    logic                  w_prodSat;
    logic [W-1:0]          w_prod;

    logic [W:0]            w_wsSum;
    logic                  w_wsSat;
    logic [W-1:0]          w_wsPsum;

    logic [AW:0]           w_accSum;
    logic                  w_accSat;
    logic [AW-1:0]         w_accNext;
    logic [AW-1:0]         w_prodExt;

    logic [AW-W:0]         w_accHigh;
    logic                  w_drainSat;
    logic [W-1:0]          w_drainVal;

    logic [W-1:0]          w_psumNext;
    logic                  w_psumValidNext;
    logic [AW-1:0]         w_accLoad;
    logic                  w_ovfSet;

    // In OS mode the weight is streamed alongside the activation, so the
    // stored active weight only feeds the multiplier in WS mode.
    assign w_mulWeight = (r_mode == MODE_OS) ? pe_weight_in : r_activeW;

    // Both operands are sign-extended to the full product width, so the
    // multiply cannot wrap. The arithmetic shift then rescales the product
    // and floors toward negative infinity.
    assign w_prodFull  = $signed({{W{pe_input_in[W-1]}}, pe_input_in})
                       * $signed({{W{w_mulWeight[W-1]}}, w_mulWeight});
    assign w_prodShift = w_prodFull >>> FRAC_BITS;

    // The shifted product fits in W bits only when every bit from the W-bit
    // sign position upward agrees.
    assign w_prodHigh = w_prodShift[PW-1:W-1];
    assign w_prodSat  = !((&w_prodHigh) || !(|w_prodHigh));
    assign w_prod     = w_prodSat ? (w_prodShift[PW-1] ? SAT_MIN : SAT_MAX)
                                  : w_prodShift[W-1:0];

    // WS adder: one guard bit. Overflow shows up as a mismatch between the
    // guard bit and the W-bit sign.
    assign w_wsSum  = W1'($signed(w_prod)) + W1'($signed(pe_psum_in));
    assign w_wsSat  = w_wsSum[W] ^ w_wsSum[W-1];
    assign w_wsPsum = w_wsSat ? (w_wsSum[W] ? SAT_MIN : SAT_MAX) : w_wsSum[W-1:0];

    // OS accumulator adder. It works at the accumulator width, which
    // includes the optional guard bits.
    assign w_prodExt = AW'($signed(w_prod));
    assign w_accSum  = AW1'($signed(r_acc)) + AW1'($signed(w_prodExt));
    assign w_accSat  = w_accSum[AW] ^ w_accSum[AW-1];
    assign w_accNext = w_accSat ? (w_accSum[AW] ? ACC_MIN : ACC_MAX) : w_accSum[AW-1:0];

    // A drain narrows the accumulator back to W bits. With no guard bits the
    // high slice is a single bit and never reports saturation.
    assign w_accHigh  = r_acc[AW-1:W-1];
    assign w_drainSat = !((&w_accHigh) || !(|w_accHigh));
    assign w_drainVal = w_drainSat ? (r_acc[AW-1] ? SAT_MIN : SAT_MAX) : r_acc[W-1:0];

    // Mode-dependent selection of the next psum output, the accumulator
    // load value and the overflow-set condition. A drain takes priority over
    // forwarding. If an upstream value arrives in the same cycle as a drain,
    // that value is lost, so the collision is reported through the sticky
    // flag.
    always_comb begin
        w_psumNext      = '0;
        w_psumValidNext = 1'b0;
        w_accLoad       = r_acc;
        w_ovfSet        = 1'b0;
        if (r_mode == MODE_WS) begin
            if (pe_valid_in) begin
                w_psumNext      = w_wsPsum;
                w_psumValidNext = 1'b1;
                w_ovfSet        = w_prodSat | w_wsSat;
            end
        end else begin
            if (pe_drain_in) begin
                w_psumNext      = w_drainVal;
                w_psumValidNext = 1'b1;
                w_accLoad       = pe_valid_in ? w_prodExt : '0;
                w_ovfSet        = w_drainSat | pe_psum_valid_in
                                | (pe_valid_in & w_prodSat);
            end else begin
                if (pe_valid_in) begin
                    w_accLoad = w_accNext;
                    w_ovfSet  = w_prodSat | w_accSat;
                end
                if (pe_psum_valid_in) begin
                    w_psumNext      = pe_psum_in;
                    w_psumValidNext = 1'b1;
                end
            end
        end
    end

    // Pass-through registers that carry activations and control strobes to
    // the east/south neighbours. The activation holds its last valid value
    // so that a bubble does not disturb the east PE's operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inputOut  <= '0;
            r_validOut  <= 1'b0;
            r_switchOut <= 1'b0;
            r_drainOut  <= 1'b0;
            r_acceptW   <= 1'b0;
        end else begin
            if (pe_valid_in) begin
                r_inputOut <= pe_input_in;
            end
            r_validOut  <= pe_valid_in;
            r_switchOut <= pe_switch_in;
            r_drainOut  <= pe_drain_in;
            r_acceptW   <= pe_accept_w_in;
        end
    end

    // Double-buffered weights. A switch promotes the old inactive value
    // even when a new weight is being loaded in the same cycle. This lets
    // the next tile's weights be preloaded while the current one computes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_activeW   <= '0;
            r_inactiveW <= '0;
            r_weightOut <= '0;
            r_mode      <= MODE_WS;
        end else begin
            if (pe_accept_w_in) begin
                r_inactiveW <= pe_weight_in;
                r_weightOut <= pe_weight_in;
            end else begin
                r_weightOut <= '0;
            end
            if (pe_switch_in) begin
                r_activeW <= r_inactiveW;
                r_mode    <= pe_pe_mode_cast(pe_mode_in);
            end
        end
    end

    function automatic pe_mode_t pe_pe_mode_cast(input logic m);
        return m ? MODE_OS : MODE_WS;
    endfunction

    // Psum output, accumulator and sticky overflow. When the flag is set and
    // cleared in the same cycle, the set wins, so a fresh overflow is never
    // lost to a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_psumOut   <= '0;
            r_psumValid <= 1'b0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
        end else begin
            r_psumOut   <= w_psumNext;
            r_psumValid <= w_psumValidNext;
            r_acc       <= w_accLoad;
            if (w_ovfSet) begin
                r_ovf <= 1'b1;
            end else if (pe_clr_ovf_in) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign pe_psum_out       = r_psumOut;
    assign pe_psum_valid_out = r_psumValid;
    assign pe_weight_out     = r_weightOut;
    assign pe_accept_w_out   = r_acceptW;
    assign pe_input_out      = r_inputOut;
    assign pe_valid_out      = r_validOut;
    assign pe_switch_out     = r_switchOut;
    assign pe_drain_out      = r_drainOut;
    assign pe_overflow_out   = r_ovf;

endmodule

// File: tb/tb_pe_v2.sv
// ============================================================================
// tb_pe_v2 -- self-checking bench for pe_v2
//
// The bench drives a directed sequence and then random traffic. A
// behavioural model written with plain integer fixed-point arithmetic
// predicts every output.
// ============================================================================
module tb_pe_v2;

    localparam int W = 16;
    localparam int F = 8;
    localparam int G = 0;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] pe_psum_in = '0;
    logic         pe_psum_valid_in = 1'b0;
    logic [W-1:0] pe_weight_in = '0;
    logic         pe_accept_w_in = 1'b0;
    logic [W-1:0] pe_input_in = '0;
    logic         pe_valid_in = 1'b0;
    logic         pe_switch_in = 1'b0;
    logic         pe_mode_in = 1'b0;
    logic         pe_drain_in = 1'b0;
    logic         pe_clr_ovf_in = 1'b0;
    logic [W-1:0] pe_psum_out;
    logic         pe_psum_valid_out;
    logic [W-1:0] pe_weight_out;
    logic         pe_accept_w_out;
    logic [W-1:0] pe_input_out;
    logic         pe_valid_out;
    logic         pe_switch_out;
    logic         pe_drain_out;
    logic         pe_overflow_out;

    int checks = 0;
    int failures = 0;

    // Model state
    longint       mActive, mInactive, mAcc;
    bit           mMode;
    logic [W-1:0] ePsum, eWeightOut, eInputOut;
    bit           ePsumValid, eAcceptOut, eValidOut, eSwitchOut, eDrainOut, eOvf;

    pe_v2 #(.DATA_WIDTH(W), .FRAC_BITS(F), .ACC_GUARD(G)) dut (
        .clk(clk), .rst_n(rst_n),
        .pe_psum_in(pe_psum_in), .pe_psum_valid_in(pe_psum_valid_in),
        .pe_weight_in(pe_weight_in), .pe_accept_w_in(pe_accept_w_in),
        .pe_input_in(pe_input_in), .pe_valid_in(pe_valid_in),
        .pe_switch_in(pe_switch_in), .pe_mode_in(pe_mode_in),
        .pe_drain_in(pe_drain_in), .pe_clr_ovf_in(pe_clr_ovf_in),
        .pe_psum_out(pe_psum_out), .pe_psum_valid_out(pe_psum_valid_out),
        .pe_weight_out(pe_weight_out), .pe_accept_w_out(pe_accept_w_out),
        .pe_input_out(pe_input_out), .pe_valid_out(pe_valid_out),
        .pe_switch_out(pe_switch_out), .pe_drain_out(pe_drain_out),
        .pe_overflow_out(pe_overflow_out)
    );

    // 100 MHz-style free-running clock
    always #5 clk = ~clk;

    function automatic longint toS(input logic [W-1:0] v);
        return longint'($signed(v));
    endfunction

    function automatic longint satTo(input longint x, input int bits);
        longint mx = (longint'(1) <<< (bits - 1)) - 1;
        longint mn = -(longint'(1) <<< (bits - 1));
        if (x > mx) return mx;
        if (x < mn) return mn;
        return x;
    endfunction

    function automatic logic [W-1:0] randVal();
        if ($urandom_range(0, 1) == 0) return W'($urandom);
        return W'(int'($urandom_range(0, 1023)) - 512);
    endfunction

    // Return the model to its post-reset state
    task automatic modelReset();
        mActive = 0; mInactive = 0; mAcc = 0; mMode = 1'b0;
        ePsum = '0; eWeightOut = '0; eInputOut = '0;
        ePsumValid = 0; eAcceptOut = 0; eValidOut = 0;
        eSwitchOut = 0; eDrainOut = 0; eOvf = 0;
    endtask

    // Advance the model by one clock using the inputs present before the edge
    task automatic modelStep(
        input logic [W-1:0] psumIn, input bit psumValid,
        input logic [W-1:0] weight, input bit accept,
        input logic [W-1:0] inp, input bit valid,
        input bit sw, input bit mode, input bit drain, input bit clr);
        longint wsel, prodRaw, prod, s, r, d, nextInactive;
        bit     psat, setOvf;
        setOvf  = 0;
        wsel    = mMode ? toS(weight) : mActive;
        prodRaw = (toS(inp) * wsel) >>> F;
        prod    = satTo(prodRaw, W);
        psat    = (prod != prodRaw);
        if (!mMode) begin
            if (valid) begin
                s = prod + toS(psumIn);
                r = satTo(s, W);
                setOvf = psat || (s != r);
                ePsum = W'(r); ePsumValid = 1;
            end else begin
                ePsum = '0; ePsumValid = 0;
            end
        end else if (drain) begin
            d = satTo(mAcc, W);
            setOvf = (d != mAcc) || psumValid || (valid && psat);
            ePsum = W'(d); ePsumValid = 1;
            mAcc = valid ? prod : 0;
        end else begin
            if (valid) begin
                s = mAcc + prod;
                r = satTo(s, W + G);
                setOvf = psat || (s != r);
                mAcc = r;
            end
            if (psumValid) begin
                ePsum = psumIn; ePsumValid = 1;
            end else begin
                ePsum = '0; ePsumValid = 0;
            end
        end
        if (setOvf) eOvf = 1;
        else if (clr) eOvf = 0;
        eWeightOut   = accept ? weight : '0;
        nextInactive = accept ? toS(weight) : mInactive;
        if (sw) begin
            mActive = mInactive;
            mMode   = mode;
        end
        mInactive = nextInactive;
        if (valid) eInputOut = inp;
        eValidOut  = valid;
        eSwitchOut = sw;
        eDrainOut  = drain;
        eAcceptOut = accept;
    endtask

    // Single comparison point: counts and reports any difference
    task automatic checkOne(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Compare every DUT output against the model prediction
    task automatic checkOutput();
        checkOne("psum_out",       32'(pe_psum_out),       32'(ePsum));
        checkOne("psum_valid_out", 32'(pe_psum_valid_out), 32'(ePsumValid));
        checkOne("weight_out",     32'(pe_weight_out),     32'(eWeightOut));
        checkOne("accept_w_out",   32'(pe_accept_w_out),   32'(eAcceptOut));
        checkOne("input_out",      32'(pe_input_out),      32'(eInputOut));
        checkOne("valid_out",      32'(pe_valid_out),      32'(eValidOut));
        checkOne("switch_out",     32'(pe_switch_out),     32'(eSwitchOut));
        checkOne("drain_out",      32'(pe_drain_out),      32'(eDrainOut));
        checkOne("overflow_out",   32'(pe_overflow_out),   32'(eOvf));
    endtask

    // Drive one cycle of inputs, step the model, then sample just after the edge
    task automatic applyStimulus(
        input logic [W-1:0] psumIn, input bit psumValid,
        input logic [W-1:0] weight, input bit accept,
        input logic [W-1:0] inp, input bit valid,
        input bit sw, input bit mode, input bit drain, input bit clr);
        pe_psum_in = psumIn; pe_psum_valid_in = psumValid;
        pe_weight_in = weight; pe_accept_w_in = accept;
        pe_input_in = inp; pe_valid_in = valid;
        pe_switch_in = sw; pe_mode_in = mode;
        pe_drain_in = drain; pe_clr_ovf_in = clr;
        modelStep(psumIn, psumValid, weight, accept, inp, valid, sw, mode, drain, clr);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    task automatic idle();
        applyStimulus('0, 0, '0, 0, '0, 0, 0, 0, 0, 0);
    endtask

    // Directed sequence followed by randomized traffic
    initial begin
        $display("[TB] start");
        modelReset();

        // Reset held while inputs toggle: outputs must stay at zero
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pe_psum_in = W'($urandom); pe_psum_valid_in = 1'($urandom);
            pe_weight_in = W'($urandom); pe_accept_w_in = 1'($urandom);
            pe_input_in = W'($urandom); pe_valid_in = 1'($urandom);
            pe_switch_in = 1'($urandom); pe_mode_in = 1'($urandom);
            pe_drain_in = 1'($urandom); pe_clr_ovf_in = 1'($urandom);
            @(posedge clk);
            #1;
            checkOutput();
        end
        rst_n = 1'b1;
        idle();
        checkOne("rst_psum_const", 32'(pe_psum_out), 32'h0000);
        checkOne("rst_ovf_const",  32'(pe_overflow_out), 32'h0);

        // WS MAC: 1.5 * 2.0 + 1.0 = 4.0
        applyStimulus('0, 0, 16'h0200, 1, '0, 0, 0, 0, 0, 0);
        applyStimulus('0, 0, '0, 0, '0, 0, 1, 0, 0, 0);
        applyStimulus(16'h0100, 1, '0, 0, 16'h0180, 1, 0, 0, 0, 0);
        checkOne("ws_mac_const",       32'(pe_psum_out), 32'h0400);
        checkOne("ws_mac_valid_const", 32'(pe_psum_valid_out), 32'h1);

        // Saturation, sticky flag, clear, and negative result
        applyStimulus('0, 0, '0, 0, 16'h7F00, 1, 0, 0, 0, 0);
        checkOne("sat_psum_const", 32'(pe_psum_out), 32'h7FFF);
        checkOne("sat_ovf_const",  32'(pe_overflow_out), 32'h1);
        idle();
        checkOne("ovf_hold_const", 32'(pe_overflow_out), 32'h1);
        applyStimulus('0, 0, '0, 0, '0, 0, 0, 0, 0, 1);
        checkOne("ovf_clr_const",  32'(pe_overflow_out), 32'h0);
        applyStimulus('0, 0, 16'h0080, 1, '0, 0, 0, 0, 0, 0);
        applyStimulus('0, 0, '0, 0, '0, 0, 1, 0, 0, 0);
        applyStimulus('0, 0, '0, 0, 16'hFF00, 1, 0, 0, 0, 0);
        checkOne("neg_mul_const", 32'(pe_psum_out), 32'hFF80);

        // Double buffer: accept and switch in the same cycle
        applyStimulus('0, 0, 16'h0100, 1, '0, 0, 0, 0, 0, 0);
        applyStimulus('0, 0, 16'h0300, 1, '0, 0, 1, 0, 0, 0);
        applyStimulus('0, 0, '0, 0, 16'h0100, 1, 0, 0, 0, 0);
        checkOne("dbuf_active_old", 32'(pe_psum_out), 32'h0100);
        applyStimulus('0, 0, '0, 0, '0, 0, 1, 0, 0, 0);
        applyStimulus('0, 0, '0, 0, 16'h0100, 1, 0, 0, 0, 0);
        checkOne("dbuf_active_new", 32'(pe_psum_out), 32'h0300);

        // OS accumulate and drain
        applyStimulus('0, 0, '0, 0, '0, 0, 1, 1, 0, 0);
        applyStimulus('0, 0, 16'h0200, 0, 16'h0100, 1, 0, 0, 0, 0);
        applyStimulus('0, 0, 16'h0100, 0, 16'h0200, 1, 0, 0, 0, 0);
        applyStimulus('0, 0, '0, 0, '0, 0, 0, 0, 1, 0);
        checkOne("os_drain_const",  32'(pe_psum_out), 32'h0400);
        checkOne("os_drain_valid",  32'(pe_psum_valid_out), 32'h1);
        applyStimulus('0, 0, '0, 0, '0, 0, 0, 0, 1, 0);
        checkOne("os_acc_cleared",  32'(pe_psum_out), 32'h0000);
        applyStimulus(16'h1234, 1, '0, 0, '0, 0, 0, 0, 0, 0);
        checkOne("os_forward",      32'(pe_psum_out), 32'h1234);
        applyStimulus('0, 0, 16'h0100, 0, 16'h0100, 1, 0, 0, 0, 0);
        applyStimulus(16'h5555, 1, '0, 0, '0, 0, 0, 0, 1, 0);
        checkOne("collide_psum",    32'(pe_psum_out), 32'h0100);
        checkOne("collide_ovf",     32'(pe_overflow_out), 32'h1);
        applyStimulus('0, 0, '0, 0, '0, 0, 0, 0, 0, 1);

        // Reset asserted mid-accumulation
        applyStimulus('0, 0, 16'h0100, 0, 16'h0300, 1, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        applyStimulus('0, 0, '0, 0, '0, 0, 1, 1, 0, 0);
        applyStimulus('0, 0, '0, 0, '0, 0, 0, 0, 1, 0);
        checkOne("rst_mid_os_drain", 32'(pe_psum_out), 32'h0000);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            applyStimulus(randVal(), ($urandom_range(0, 2) == 0),
                          randVal(), ($urandom_range(0, 2) == 0),
                          randVal(), ($urandom_range(0, 1) == 0),
                          ($urandom_range(0, 7) == 0), 1'($urandom),
                          ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pe_v2.md
Name: pe_v2

Overview:
Parametrised next-generation processing element for the systolic array. It generalises the weight-stationary MAC PE in four ways: configurable fixed-point width and fraction bits, saturating arithmetic with a sticky overflow flag, a registered psum output, and a runtime-selectable output-stationary mode with a local accumulator and drain chain. It tiles in the same north/west to south/east grid as the existing PE.

Parameters:
DATA_WIDTH, 16, width of inputs, weights and psums (two's complement).
FRAC_BITS, 8, fractional bits of the fixed-point format (Q(DATA_WIDTH-FRAC_BITS).FRAC_BITS).
ACC_GUARD, 0, extra integer bits on the OS accumulator; the value is saturated to DATA_WIDTH on drain.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
pe_psum_in  in  DATA_WIDTH  north psum (WS) or upstream drained value (OS).
pe_psum_valid_in  in  1  qualifies pe_psum_in.
pe_weight_in  in  DATA_WIDTH  north weight.
pe_accept_w_in  in  1  weight-load strobe from the north.
pe_input_in  in  DATA_WIDTH  west activation.
pe_valid_in  in  1  qualifies pe_input_in.
pe_switch_in  in  1  swap weight buffers and latch mode.
pe_mode_in  in  1  0 = weight-stationary (WS), 1 = output-stationary (OS); sampled only on switch.
pe_drain_in  in  1  OS only: emit and clear the accumulator.
pe_clr_ovf_in  in  1  clears the sticky overflow flag.
pe_psum_out  out  DATA_WIDTH  registered south psum.
pe_psum_valid_out  out  1  qualifies pe_psum_out.
pe_weight_out  out  DATA_WIDTH  registered south weight.
pe_accept_w_out  out  1  registered pe_accept_w_in.
pe_input_out  out  DATA_WIDTH  registered east activation.
pe_valid_out  out  1  registered pe_valid_in.
pe_switch_out  out  1  registered pe_switch_in.
pe_drain_out  out  1  registered pe_drain_in (propagates east).
pe_overflow_out  out  1  sticky saturation/collision flag.

Behaviour:
- Reset (rst_n=0, asynchronous): every output, both weight registers, the accumulator, and the mode register (WS) go to 0.
- Multiply: full 2*DATA_WIDTH signed product, arithmetic shift right by FRAC_BITS (truncate toward negative infinity), then saturate to [-2^(W-1), 2^(W-1)-1].
- Add: signed add with one extra bit, saturated the same way.
- Any saturation sets pe_overflow_out. The flag holds until pe_clr_ovf_in. If a set and a clear occur in the same cycle, set wins.
- Pass-through, latency 1: pe_input_out <= pe_input_in when pe_valid_in, otherwise it holds. pe_valid_out, pe_switch_out, pe_drain_out and pe_accept_w_out are registered copies of their inputs.
- Weights: when pe_accept_w_in=1, inactive <= pe_weight_in and pe_weight_out <= pe_weight_in; otherwise pe_weight_out <= 0.
- Switch: when pe_switch_in=1, active <= inactive (the old value) and mode <= pe_mode_in. If switch and accept occur in the same cycle, active takes the old inactive value and inactive takes the new weight.
- WS mode, latency 1:
  - pe_valid_in=1: pe_psum_out <= sat(mul(pe_input_in, active) + pe_psum_in) and pe_psum_valid_out <= 1.
  - pe_valid_in=0: pe_psum_out <= 0 and pe_psum_valid_out <= 0.
  - pe_drain_in is ignored.
- OS mode:
  - Multiplier operands are pe_input_in and pe_weight_in (streamed). When pe_valid_in=1, acc <= sat(acc + product).
  - Drain (pe_drain_in=1): pe_psum_out <= sat_W(acc) and pe_psum_valid_out <= 1. acc is reloaded with the product if pe_valid_in=1 in the same cycle, otherwise with 0.
  - Otherwise, if pe_psum_valid_in=1: forward pe_psum_in to pe_psum_out with valid=1, latency 1.
  - Otherwise: pe_psum_out <= 0 and valid <= 0.
  - Drain and pe_psum_valid_in in the same cycle: drain wins, the upstream value is dropped, and pe_overflow_out is set.
- Mode switch mid-accumulation: acc is preserved but is not used in WS mode. The next OS drain emits the retained value.
- Reset asserted mid-operation clears all state immediately. There is no recovery of in-flight data.

Test Plan:
- Reset: hold rst_n=0 with all inputs toggling -> all outputs stay 0. Release rst_n -> pe_psum_out=0x0000, pe_overflow_out=0.
- WS MAC (W=16, F=8): load 0x0200 (2.0), switch, then drive input 0x0180 (1.5) with psum_in 0x0100 -> one cycle later pe_psum_out=0x0400, pe_psum_valid_out=1.
- Saturation: active=0x0200, input 0x7F00 -> pe_psum_out=0x7FFF and pe_overflow_out=1. Flag holds until pe_clr_ovf_in. Input 0xFF00 (-1.0) with weight 0x0080 -> 0xFF80.
- Double buffer: accept 0x0300 in the same cycle as switch, with inactive=0x0100 -> active=0x0100 and inactive=0x0300. The next switch makes active=0x0300.
- OS accumulate: mode=1. Stream pairs (0x0100,0x0200) and (0x0200,0x0100), then drain -> pe_psum_out=0x0400, valid=1, acc=0. Drain in the same cycle as psum_valid_in -> drained value emitted and overflow set.
- Reset mid-OS: assert rst_n=0 with acc=0x0300 -> a subsequent drain emits 0x0000.
